alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes the low 32 bits of A*B (RV32M MUL; the same result for signed and unsigned operands) by shift-and-add.
- It borrows the shared 32-bit ALU one operation per cycle.
- Sits beside the execute stage. It requests the ALU through a req/gnt handshake, drives the ALU operand and control inputs when granted, and captures ALUResult.
- Uses ALU codes 4'b0000 (ADD) and 4'b0101 (SLL) only.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a multiply; sampled only in IDLE
- op_a  in  WIDTH  multiplicand, latched on accepted start
- op_b  in  WIDTH  multiplier, latched on accepted start
- alu_req  out  1  ALU wanted this cycle
- alu_gnt  in  1  ALU granted to this block this cycle (combinational from arbiter)
- alu_srca  out  WIDTH  to ALU SrcA
- alu_srcb  out  WIDTH  to ALU SrcB
- alu_ctrl  out  4  to ALU ALUControl
- alu_result  in  WIDTH  from ALU ALUResult (combinational, same cycle)
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle pulse: product valid
- product  out  WIDTH  registered result; held until next done

Behaviour:
- Internal registers: acc, mcand, mplier (WIDTH each), 2-bit state.
- States: IDLE, ADD, SHIFT, DONE.
- Reset (async, rst=1), all cleared immediately:
  - state=IDLE; acc=mcand=mplier=0; product=0.
  - done=0, busy=0, alu_req=0.
  - alu_srca=0, alu_srcb=0, alu_ctrl=4'b0000.
  - Reset mid-operation aborts with no done pulse; the next start after reset release behaves normally.
- IDLE:
  - alu_req=0; ALU outputs held at 0/0/4'b0000.
  - On start=1: acc<=0, mcand<=op_a, mplier<=op_b.
  - Next state: op_b==0 -> DONE; op_b[0]==1 -> ADD; else SHIFT.
- ADD:
  - Drives alu_req=1, alu_ctrl=0000, alu_srca=acc, alu_srcb=mcand.
  - If alu_gnt: acc<=alu_result; next SHIFT.
  - If !alu_gnt: all registers hold, state holds (stall).
- SHIFT:
  - Drives alu_req=1, alu_ctrl=0101, alu_srca=mcand, alu_srcb=1.
  - If alu_gnt: mcand<=alu_result; mplier<=mplier>>1 (logical, local shift, not via ALU).
  - Next state uses m1=mplier>>1: m1==0 -> DONE; mplier[1]==1 -> ADD; else SHIFT.
  - If !alu_gnt: hold.
- DONE:
  - done=1 for exactly one cycle; product<=acc (product changes on the clock edge that enters DONE? no — product updates on the same edge done rises, so product is valid whenever done=1).
  - Next state IDLE; alu_req=0.
- busy=1 in ADD, SHIFT and DONE.
- start while busy is ignored; there is no queueing.
- alu_req is a pure function of state and never depends on alu_gnt.
- ALU operand/control outputs are combinational from state and registers, so the arbiter may mux them freely.
- Arithmetic is modulo 2^WIDTH: overflow bits are dropped by the ALU and not detected.
- Latency with alu_gnt tied high: done asserts N cycles after the start-accept edge, N = 1 + popcount(op_b) + (msb_index(op_b)+1).
  - op_b==0: N=1.
  - Maximum: N=65 for op_b=0xFFFFFFFF.
  - Each cycle with alu_gnt=0 in ADD or SHIFT adds exactly one cycle.
- Early termination relies on mplier reaching 0; there is no iteration counter, and at most 32 SHIFTs can occur.

Test Plan:
- Basic: op_a=6, op_b=7, gnt=1 -> done in cycle 7 after the accept edge, product=42. Bench monitor sees ALU codes in order ADD, SLL, ADD, SLL, ADD, SLL.
- Zero/one: op_b=0, op_a=0x1234 -> done at cycle 1, product=0, alu_req never asserted. op_a=0xDEADBEEF, op_b=1 -> done at cycle 3, product=0xDEADBEEF.
- Wrap/max: op_a=op_b=0xFFFFFFFF -> done at cycle 65, product=0x00000001. op_a=0x80000000, op_b=2 -> product=0.
- Stall: 6*7 with alu_gnt low for 3 cycles inside the first SHIFT -> done at cycle 10, product=42, registers unchanged during the stall.
- Busy start: pulse start with new operands (9,9) mid-operation -> ignored; the first result is still 42, and busy falls only after done.
- Reset mid-op: assert rst during ADD -> outputs 0 immediately, no done pulse. A subsequent 3*5 -> product=15.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiplier (low WIDTH bits) that borrows the shared ALU
module alu_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]       ALU_ADD = 4'b0000;
    localparam logic [3:0]       ALU_SLL = 4'b0101;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0] m1;

    assign m1 = mplier_q >> 1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        alu_req   = 1'b0;
        alu_srca  = '0;
        alu_srcb  = '0;
        alu_ctrl  = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    if (op_b == '0) begin
                        state_d = S_DONE;
                    end else if (op_b[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_ADD: begin
                alu_req  = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_srca = acc_q;
                alu_srcb = mcand_q;
                if (alu_gnt) begin
                    acc_d   = alu_result;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                alu_req  = 1'b1;
                alu_ctrl = ALU_SLL;
                alu_srca = mcand_q;
                alu_srcb = ONE;
                if (alu_gnt) begin
                    mcand_d  = alu_result;
                    mplier_d = m1;
                    // Terminate as soon as no multiplier bits remain; m1[0] is the next bit to inspect.
                    if (m1 == '0) begin
                        state_d = S_DONE;
                    end else if (m1[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture on the edge entering DONE so product is already valid while done is high.
        if (state_d == S_DONE) begin
            product_d = acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized and directed bench for alu_mul_sequencer
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_ctrl;
    logic        busy, done;
    logic [31:0] product;

    int total = 0;
    int bad   = 0;

    alu_mul_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign alu_result = (alu_ctrl == 4'b0000) ? alu_srca + alu_srcb :
                        (alu_ctrl == 4'b0101) ? alu_srca << alu_srcb[4:0] : 32'hBAD0BAD0;

    // Reference model outputs
    logic [31:0] exp_ctrl[$], exp_sa[$], exp_sb[$];
    logic [31:0] exp_prod;
    int          exp_lat;

    // Observations from the last run
    logic [31:0] obs_ctrl[$], obs_sa[$], obs_sb[$];
    int          r_lat, r_stalls, r_req_cycles, r_stall_changed, r_busy_drop;
    logic [31:0] r_prod;
    logic        r_timeout, r_done_after, r_busy_after;

    task automatic build_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] acc, mc;
        int msb;
        exp_ctrl.delete(); exp_sa.delete(); exp_sb.delete();
        exp_prod = a * b;
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        exp_lat = 1 + $countones(b) + (msb + 1);
        acc = 0;
        mc  = a;
        for (int i = 0; i <= msb; i++) begin
            if (b[i]) begin
                exp_ctrl.push_back(32'h0); exp_sa.push_back(acc); exp_sb.push_back(mc);
                acc = acc + mc;
            end
            exp_ctrl.push_back(32'h5); exp_sa.push_back(mc); exp_sb.push_back(32'd1);
            mc = mc * 2;
        end
    endtask

    function automatic int ops_mismatch();
        int n;
        n = (obs_ctrl.size() == exp_ctrl.size()) ? 0 : 1;
        for (int i = 0; i < obs_ctrl.size() && i < exp_ctrl.size(); i++)
            if (obs_ctrl[i] !== exp_ctrl[i] || obs_sa[i] !== exp_sa[i] || obs_sb[i] !== exp_sb[i]) n++;
        return n;
    endfunction

    // mode: 0 gnt high, 1 random gnt, 2 gnt low 3 cycles in first SHIFT, 3 start pulse (9,9) mid-op
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int mode);
        int cyc, stall_left;
        logic prev_stalled;
        logic [31:0] prev_sa, prev_sb;
        obs_ctrl.delete(); obs_sa.delete(); obs_sb.delete();
        r_lat = -1; r_stalls = 0; r_req_cycles = 0; r_stall_changed = 0; r_busy_drop = 0;
        r_prod = 32'hx; r_timeout = 1'b0;
        stall_left = (mode == 2) ? 3 : 0;
        prev_stalled = 1'b0; prev_sa = 0; prev_sb = 0;
        @(posedge clk); #1;
        op_a = a; op_b = b; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (1) begin
            if (mode == 3 && cyc == 3) begin start = 1'b1; op_a = 9; op_b = 9; end
            if (mode == 3 && cyc == 4) start = 1'b0;
            if (mode == 1) alu_gnt = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && stall_left > 0 && alu_req && alu_ctrl == 4'b0101) begin
                alu_gnt = 1'b0; stall_left--;
            end else alu_gnt = 1'b1;
            #1;
            if (done) begin
                r_lat = cyc; r_prod = product;
                break;
            end
            if (!busy) r_busy_drop++;
            if (prev_stalled && (alu_srca !== prev_sa || alu_srcb !== prev_sb)) r_stall_changed++;
            prev_stalled = 1'b0;
            if (alu_req) begin
                r_req_cycles++;
                if (alu_gnt) begin
                    obs_ctrl.push_back({28'd0, alu_ctrl}); obs_sa.push_back(alu_srca); obs_sb.push_back(alu_srcb);
                end else begin
                    r_stalls++; prev_stalled = 1'b1; prev_sa = alu_srca; prev_sb = alu_srcb;
                end
            end
            if (cyc >= 400) begin r_timeout = 1'b1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        @(posedge clk); #2;
        r_done_after = done;
        r_busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; alu_gnt = 1'b0; op_a = 0; op_b = 0;
        #12;
        total++; if ({busy, done, alu_req} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, alu_req}); end
        total++; if (product !== 32'd0) begin bad++; $display("FAIL reset_product got=%h want=0", product); end
        total++; if ({alu_srca, alu_srcb, alu_ctrl} !== 68'd0) begin bad++; $display("FAIL reset_alu_out got=%h/%h/%h want=0", alu_srca, alu_srcb, alu_ctrl); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_basic();
        build_model(32'd6, 32'd7);
        do_mul(32'd6, 32'd7, 0);
        total++; if (r_timeout !== 1'b0 || r_lat !== 7) begin bad++; $display("FAIL basic_latency got=%0d want=7", r_lat); end
        total++; if (r_prod !== 32'd42) begin bad++; $display("FAIL basic_product got=%0d want=42", r_prod); end
        total++; if (ops_mismatch() !== 0) begin bad++; $display("FAIL basic_ops got=%0d_ops want=%0d_ops", obs_ctrl.size(), exp_ctrl.size()); end
        total++; if (r_done_after !== 1'b0 || r_busy_after !== 1'b0 || r_busy_drop !== 0) begin bad++; $display("FAIL basic_done_pulse got=%b%b/%0d want=00/0", r_done_after, r_busy_after, r_busy_drop); end
    endtask

    task automatic test_zero_one();
        build_model(32'h1234, 32'd0);
        do_mul(32'h1234, 32'd0, 0);
        total++; if (r_lat !== 1 || r_prod !== 32'd0) begin bad++; $display("FAIL zero_b got=%0d/%h want=1/0", r_lat, r_prod); end
        total++; if (r_req_cycles !== 0) begin bad++; $display("FAIL zero_b_req got=%0d want=0", r_req_cycles); end
        build_model(32'hDEADBEEF, 32'd1);
        do_mul(32'hDEADBEEF, 32'd1, 0);
        total++; if (r_lat !== 3 || r_prod !== 32'hDEADBEEF) begin bad++; $display("FAIL one_b got=%0d/%h want=3/deadbeef", r_lat, r_prod); end
        total++; if (ops_mismatch() !== 0) begin bad++; $display("FAIL one_b_ops got=%0d want=%0d", obs_ctrl.size(), exp_ctrl.size()); end
    endtask

    task automatic test_wrap();
        build_model(32'hFFFFFFFF, 32'hFFFFFFFF);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        total++; if (r_lat !== 65 || r_prod !== 32'd1) begin bad++; $display("FAIL max_wrap got=%0d/%h want=65/1", r_lat, r_prod); end
        total++; if (ops_mismatch() !== 0) begin bad++; $display("FAIL max_ops got=%0d want=%0d", obs_ctrl.size(), exp_ctrl.size()); end
        do_mul(32'h80000000, 32'd2, 0);
        total++; if (r_prod !== 32'd0 || r_lat !== 4) begin bad++; $display("FAIL overflow got=%h/%0d want=0/4", r_prod, r_lat); end
    endtask

    task automatic test_stall();
        build_model(32'd6, 32'd7);
        do_mul(32'd6, 32'd7, 2);
        total++; if (r_lat !== 10 || r_prod !== 32'd42) begin bad++; $display("FAIL stall got=%0d/%0d want=10/42", r_lat, r_prod); end
        total++; if (r_stalls !== 3 || r_stall_changed !== 0) begin bad++; $display("FAIL stall_hold got=%0d/%0d want=3/0", r_stalls, r_stall_changed); end
        total++; if (ops_mismatch() !== 0) begin bad++; $display("FAIL stall_ops got=%0d want=%0d", obs_ctrl.size(), exp_ctrl.size()); end
    endtask

    task automatic test_busy_start();
        build_model(32'd6, 32'd7);
        do_mul(32'd6, 32'd7, 3);
        total++; if (r_lat !== 7 || r_prod !== 32'd42) begin bad++; $display("FAIL busy_start got=%0d/%0d want=7/42", r_lat, r_prod); end
        total++; if (r_busy_drop !== 0 || r_busy_after !== 1'b0 || r_done_after !== 1'b0) begin bad++; $display("FAIL busy_start_busy got=%0d/%b%b want=0/00", r_busy_drop, r_busy_after, r_done_after); end
    endtask

    task automatic test_reset_midop();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        op_a = 6; op_b = 7; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (alu_req !== 1'b1 || alu_ctrl !== 4'b0000) begin bad++; $display("FAIL midop_in_add got=%b/%h want=1/0", alu_req, alu_ctrl); end
        rst = 1'b1;
        #1;
        total++; if ({alu_req, busy, done} !== 3'b000 || product !== 32'd0 || {alu_srca, alu_srcb, alu_ctrl} !== 68'd0) begin
            bad++; $display("FAIL midop_reset got=%b%b%b/%h/%h/%h want=000/0/0/0", alu_req, busy, done, product, alu_srca, alu_srcb);
        end
        for (int i = 0; i < 3; i++) begin @(posedge clk); #2; if (done) dones++; end
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #2; if (done || busy) dones++; end
        total++; if (dones !== 0) begin bad++; $display("FAIL midop_no_done got=%0d want=0", dones); end
        build_model(32'd3, 32'd5);
        do_mul(32'd3, 32'd5, 0);
        total++; if (r_prod !== 32'd15 || r_lat !== exp_lat) begin bad++; $display("FAIL after_reset got=%0d/%0d want=15/%0d", r_prod, r_lat, exp_lat); end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 12; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            build_model(a, b);
            do_mul(a, b, 1);
            total++; if (r_timeout !== 1'b0 || r_prod !== exp_prod) begin bad++; $display("FAIL rand_product a=%h b=%h got=%h want=%h", a, b, r_prod, exp_prod); end
            total++; if (r_lat !== exp_lat + r_stalls) begin bad++; $display("FAIL rand_latency a=%h b=%h got=%0d want=%0d", a, b, r_lat, exp_lat + r_stalls); end
            total++; if (ops_mismatch() !== 0 || r_stall_changed !== 0) begin bad++; $display("FAIL rand_ops a=%h b=%h got=%0d want=%0d", a, b, obs_ctrl.size(), exp_ctrl.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_one();
        test_wrap();
        test_stall();
        test_busy_start();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
